// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and default widths for the memory controller
package mem_pkg;

  typedef enum logic [2:0] {
    CH_IDLE,
    CH_READ_WAITING,
    CH_WRITE_WAITING,
    CH_READ_RELAYING,
    CH_WRITE_RELAYING
  } channel_state_e;

  localparam int DEF_ADDR_BITS     = 8;
  localparam int DEF_DATA_BITS     = 16;
  localparam int DEF_NUM_CONSUMERS = 4;
  localparam int DEF_NUM_CHANNELS  = 1;

  // Index width that stays legal when there is only one consumer.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_channel_fsm.sv
// rtl/mem_channel_fsm.sv - one memory channel: claim a consumer, issue to memory, relay the result
module mem_channel_fsm
  import mem_pkg::*;
#(
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int NUM_CONSUMERS = DEF_NUM_CONSUMERS,
  parameter int WRITE_ENABLE  = 1,
  localparam int IDX_BITS     = idx_bits(NUM_CONSUMERS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] read_address,
  input  logic [NUM_CONSUMERS-1:0]           write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] write_data,
  input  logic [NUM_CONSUMERS-1:0]           claimed,
  output logic [NUM_CONSUMERS-1:0]           take,
  output logic [NUM_CONSUMERS-1:0]           freed,
  input  logic                               mem_read_ready,
  input  logic                               mem_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  output logic                               read_done,
  output logic                               write_done,
  output logic                               read_capture,
  output logic [IDX_BITS-1:0]                idx
);

  channel_state_e        state, state_next;
  logic [IDX_BITS-1:0]   idx_q, idx_next;
  logic [ADDR_BITS-1:0]  addr_q, addr_next;
  logic [DATA_BITS-1:0]  data_q, data_next;
  logic                  found;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= CH_IDLE;
      idx_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state  <= state_next;
      idx_q  <= idx_next;
      addr_q <= addr_next;
      data_q <= data_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx_q;
    addr_next  = addr_q;
    data_next  = data_q;
    take       = '0;
    freed      = '0;
    found      = 1'b0;
    case (state)
      CH_IDLE: begin
        // Lowest unclaimed index wins; a read beats a write from the same consumer.
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
          if (!found && !claimed[i]) begin
            if (read_valid[i]) begin
              found      = 1'b1;
              take[i]    = 1'b1;
              idx_next   = IDX_BITS'(i);
              addr_next  = read_address[i*ADDR_BITS +: ADDR_BITS];
              state_next = CH_READ_WAITING;
            end else if (WRITE_ENABLE != 0 && write_valid[i]) begin
              found      = 1'b1;
              take[i]    = 1'b1;
              idx_next   = IDX_BITS'(i);
              addr_next  = write_address[i*ADDR_BITS +: ADDR_BITS];
              data_next  = write_data[i*DATA_BITS +: DATA_BITS];
              state_next = CH_WRITE_WAITING;
            end
          end
        end
      end
      CH_READ_WAITING: begin
        if (mem_read_ready) state_next = CH_READ_RELAYING;
      end
      CH_WRITE_WAITING: begin
        if (mem_write_ready) state_next = CH_WRITE_RELAYING;
      end
      CH_READ_RELAYING: begin
        if (!read_valid[idx_q]) begin
          freed[idx_q] = 1'b1;
          state_next   = CH_IDLE;
        end
      end
      CH_WRITE_RELAYING: begin
        if (!write_valid[idx_q]) begin
          freed[idx_q] = 1'b1;
          state_next   = CH_IDLE;
        end
      end
      default: state_next = CH_IDLE;
    endcase
  end

  assign mem_read_valid    = (state == CH_READ_WAITING);
  assign mem_read_address  = addr_q;
  assign mem_write_valid   = (WRITE_ENABLE != 0) && (state == CH_WRITE_WAITING);
  assign mem_write_address = (WRITE_ENABLE != 0) ? addr_q : '0;
  assign mem_write_data    = (WRITE_ENABLE != 0) ? data_q : '0;
  assign read_done         = (state == CH_READ_RELAYING);
  assign write_done        = (WRITE_ENABLE != 0) && (state == CH_WRITE_RELAYING);
  assign read_capture      = (state == CH_READ_WAITING) && mem_read_ready;
  assign idx               = idx_q;

endmodule

// File: rtl/mem_controller.sv
// rtl/mem_controller.sv - arbitrates consumer read/write requests onto memory channels
module mem_controller
  import mem_pkg::*;
#(
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int NUM_CONSUMERS = DEF_NUM_CONSUMERS,
  parameter int NUM_CHANNELS  = DEF_NUM_CHANNELS,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int IDX_BITS = idx_bits(NUM_CONSUMERS);

  logic [NUM_CONSUMERS-1:0] claims;
  logic [NUM_CONSUMERS-1:0] claim_chain [NUM_CHANNELS+1];
  logic [NUM_CONSUMERS-1:0] ch_take     [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] ch_freed    [NUM_CHANNELS];
  logic [IDX_BITS-1:0]      ch_idx      [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  ch_read_done, ch_write_done, ch_capture;
  logic [NUM_CONSUMERS-1:0] all_freed;
  logic [DATA_BITS-1:0]     rdata_q     [NUM_CONSUMERS];

  // Each channel sees the registered claims plus whatever earlier channels take this cycle.
  assign claim_chain[0] = claims;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    assign claim_chain[c+1] = claim_chain[c] | ch_take[c];

    mem_channel_fsm #(
      .ADDR_BITS     (ADDR_BITS),
      .DATA_BITS     (DATA_BITS),
      .NUM_CONSUMERS (NUM_CONSUMERS),
      .WRITE_ENABLE  (WRITE_ENABLE)
    ) u_fsm (
      .clk               (clk),
      .reset             (reset),
      .read_valid        (consumer_read_valid),
      .read_address      (consumer_read_address),
      .write_valid       (consumer_write_valid),
      .write_address     (consumer_write_address),
      .write_data        (consumer_write_data),
      .claimed           (claim_chain[c]),
      .take              (ch_take[c]),
      .freed             (ch_freed[c]),
      .mem_read_ready    (mem_read_ready[c]),
      .mem_write_ready   (mem_write_ready[c]),
      .mem_read_valid    (mem_read_valid[c]),
      .mem_read_address  (mem_read_address[c*ADDR_BITS +: ADDR_BITS]),
      .mem_write_valid   (mem_write_valid[c]),
      .mem_write_address (mem_write_address[c*ADDR_BITS +: ADDR_BITS]),
      .mem_write_data    (mem_write_data[c*DATA_BITS +: DATA_BITS]),
      .read_done         (ch_read_done[c]),
      .write_done        (ch_write_done[c]),
      .read_capture      (ch_capture[c]),
      .idx               (ch_idx[c])
    );
  end

  always_comb begin
    all_freed            = '0;
    consumer_read_ready  = '0;
    consumer_write_ready = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      all_freed = all_freed | ch_freed[c];
      if (ch_read_done[c])  consumer_read_ready[ch_idx[c]]  = 1'b1;
      if (ch_write_done[c]) consumer_write_ready[ch_idx[c]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      claims <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) rdata_q[i] <= '0;
    end else begin
      claims <= claim_chain[NUM_CHANNELS] & ~all_freed;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (ch_capture[c]) rdata_q[ch_idx[c]] <= mem_read_data[c*DATA_BITS +: DATA_BITS];
      end
    end
  end

  for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_rdata
    assign consumer_read_data[i*DATA_BITS +: DATA_BITS] = rdata_q[i];
  end

endmodule

// File: tb/tb_mem_controller.sv
// tb/tb_mem_controller.sv - self-checking bench: 1-channel read/write controller and 2-channel read-only controller
module tb_mem_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Instance A: defaults (1 channel, writes enabled), memory with programmable latency.
  logic [3:0]  rv_a = '0, wv_a = '0, rr_a, wr_a;
  logic [31:0] ra_a = '0, wa_a = '0;
  logic [63:0] wd_a = '0, rd_a;
  logic        mrv_a, mrr_a, mwv_a, mwr_a;
  logic [7:0]  mra_a, mwa_a;
  logic [15:0] mrd_a, mwd_a;

  // Instance B: 2 channels, read-only, single-cycle memory.
  logic [3:0]  rv_b = '0, wv_b = '0, rr_b, wr_b;
  logic [31:0] ra_b = '0, wa_b = '0;
  logic [63:0] wd_b = '0, rd_b;
  logic [1:0]  mrv_b, mrr_b, mwv_b, mwr_b;
  logic [15:0] mra_b, mwa_b;
  logic [31:0] mrd_b, mwd_b;

  logic [15:0] ref_mem [256];
  logic [15:0] mem_a   [256];
  int          lat_a = 1;
  int          cnt_a = 0;
  logic        stray_a = 1'b0;

  mem_controller dut_a (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv_a), .consumer_read_address(ra_a),
    .consumer_read_ready(rr_a), .consumer_read_data(rd_a),
    .consumer_write_valid(wv_a), .consumer_write_address(wa_a),
    .consumer_write_data(wd_a), .consumer_write_ready(wr_a),
    .mem_read_valid(mrv_a), .mem_read_address(mra_a),
    .mem_read_ready(mrr_a), .mem_read_data(mrd_a),
    .mem_write_valid(mwv_a), .mem_write_address(mwa_a),
    .mem_write_data(mwd_a), .mem_write_ready(mwr_a)
  );

  mem_controller #(.NUM_CHANNELS(2), .WRITE_ENABLE(0)) dut_b (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv_b), .consumer_read_address(ra_b),
    .consumer_read_ready(rr_b), .consumer_read_data(rd_b),
    .consumer_write_valid(wv_b), .consumer_write_address(wa_b),
    .consumer_write_data(wd_b), .consumer_write_ready(wr_b),
    .mem_read_valid(mrv_b), .mem_read_address(mra_b),
    .mem_read_ready(mrr_b), .mem_read_data(mrd_b),
    .mem_write_valid(mwv_b), .mem_write_address(mwa_b),
    .mem_write_data(mwd_b), .mem_write_ready(mwr_b)
  );

  // Memory A answers in the lat_a-th cycle a request is held; stray_a injects a spurious ready.
  assign mrr_a = (mrv_a && cnt_a == lat_a - 1) || stray_a;
  assign mwr_a = mwv_a && cnt_a == lat_a - 1;
  assign mrd_a = mem_a[mra_a];

  always @(posedge clk) begin
    if ((mrv_a && !mrr_a) || (mwv_a && !mwr_a)) cnt_a <= cnt_a + 1;
    else cnt_a <= 0;
    if (reset) begin
      for (int i = 0; i < 256; i++) mem_a[i] = ref_mem[i];
    end else if (mwv_a && mwr_a) begin
      mem_a[mwa_a] = mwd_a;
    end
  end

  assign mrr_b = mrv_b;
  assign mwr_b = 2'b11;
  assign mrd_b = {ref_mem[mra_b[15:8]], ref_mem[mra_b[7:0]]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called right after a negedge; a read completes lat_a+1 cycles after it is presented.
  task automatic read_a(input int c, input logic [7:0] a);
    int n = 0;
    bit issued = 1'b0;
    rv_a[c] = 1'b1;
    ra_a[c*8 +: 8] = a;
    do begin
      @(negedge clk);
      n++;
      if (mrv_a && !issued) begin
        issued = 1'b1;
        check("rd_addr", 32'(mra_a), 32'(a));
      end
    end while (!rr_a[c] && n < 60);
    check("rd_lat", n, lat_a + 1);
    check("rd_data", 32'(rd_a[c*16 +: 16]), 32'(ref_mem[a]));
    @(negedge clk);
    check("rd_hold", 32'(rr_a[c]), 1);
    rv_a[c] = 1'b0;
    @(negedge clk);
    check("rd_drop", 32'(rr_a[c]), 0);
  endtask

  task automatic write_a(input int c, input logic [7:0] a, input logic [15:0] d);
    int n = 0;
    bit issued = 1'b0;
    wv_a[c] = 1'b1;
    wa_a[c*8 +: 8] = a;
    wd_a[c*16 +: 16] = d;
    do begin
      @(negedge clk);
      n++;
      if (mwv_a && !issued) begin
        issued = 1'b1;
        check("wr_addr", 32'(mwa_a), 32'(a));
        check("wr_wdata", 32'(mwd_a), 32'(d));
      end
    end while (!wr_a[c] && n < 60);
    check("wr_lat", n, lat_a + 1);
    wv_a[c] = 1'b0;
    @(negedge clk);
    check("wr_drop", 32'(wr_a[c]), 0);
    check("wr_mem", 32'(mem_a[a]), 32'(d));
    ref_mem[a] = d;
  endtask

  // Two consumers read together: the lower index goes first, the higher one is
  // issued only once the lower has released.
  task automatic contend_a(input int lo, input int hi, input logic [7:0] alo, input logic [7:0] ahi);
    int t = 0, t_lo = -1, t_hi = -1;
    rv_a[lo] = 1'b1; ra_a[lo*8 +: 8] = alo;
    rv_a[hi] = 1'b1; ra_a[hi*8 +: 8] = ahi;
    while (t_hi < 0 && t < 80) begin
      @(negedge clk);
      t++;
      if (t_lo < 0 && rr_a[lo]) begin
        t_lo = t;
        check("cont_lo_data", 32'(rd_a[lo*16 +: 16]), 32'(ref_mem[alo]));
        rv_a[lo] = 1'b0;
      end
      if (t_hi < 0 && rr_a[hi]) begin
        t_hi = t;
        check("cont_hi_data", 32'(rd_a[hi*16 +: 16]), 32'(ref_mem[ahi]));
        rv_a[hi] = 1'b0;
      end
    end
    check("cont_lo_time", t_lo, lat_a + 1);
    check("cont_hi_time", t_hi, 2 * lat_a + 3);
    @(negedge clk);
    check("cont_hi_drop", 32'(rr_a[hi]), 0);
    check("cont_lo_held", 32'(rd_a[lo*16 +: 16]), 32'(ref_mem[alo]));
  endtask

  initial begin
    logic [7:0]  a0, a1;
    logic [15:0] d;
    int          lo, hi, t_ro;
    bit          wr_seen;

    for (int i = 0; i < 256; i++) ref_mem[i] = 16'($urandom);
    ref_mem[8'h10] = 16'h1234;
    repeat (3) @(negedge clk);
    check("rst_a_outs", {22'd0, rr_a, wr_a, mrv_a, mwv_a}, 0);
    check("rst_a_addr", {16'd0, mra_a, mwa_a}, 0);
    check("rst_a_rdata", 32'(|rd_a), 0);
    check("rst_b_outs", {20'd0, rr_b, wr_b, mrv_b, mwv_b}, 0);
    check("rst_b_rdata", 32'(|rd_b), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single read and single write with a 1-cycle memory.
    read_a(2, 8'h10);
    write_a(1, 8'h20, 16'hBEEF);

    // Read and write pending together on one consumer: read goes first.
    rv_a[0] = 1'b1; ra_a[7:0] = 8'h30;
    wv_a[0] = 1'b1; wa_a[7:0] = 8'h31; wd_a[15:0] = 16'h5A5A;
    @(negedge clk);
    check("both_read_first", {30'd0, mrv_a, mwv_a}, 2);
    @(negedge clk);
    check("both_rd_ready", 32'(rr_a[0]), 1);
    check("both_rd_data", 32'(rd_a[15:0]), 32'(ref_mem[8'h30]));
    rv_a[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("both_wr_ready", 32'(wr_a[0]), 1);
    wv_a[0] = 1'b0;
    @(negedge clk);
    check("both_wr_mem", 32'(mem_a[8'h31]), 32'h5A5A);
    ref_mem[8'h31] = 16'h5A5A;

    // Contention on the single channel: directed pair, then random pairs and latencies.
    contend_a(0, 3, 8'h44, 8'h55);
    for (int k = 0; k < 4; k++) begin
      lo = $urandom_range(0, 2);
      hi = $urandom_range(lo + 1, 3);
      lat_a = $urandom_range(1, 3);
      contend_a(lo, hi, 8'($urandom), 8'($urandom));
    end

    // Random single transactions over a small window so reads see earlier writes.
    for (int k = 0; k < 20; k++) begin
      lat_a = $urandom_range(1, 4);
      a0 = 8'h40 + 8'($urandom_range(0, 7));
      d  = 16'($urandom);
      if ($urandom_range(0, 1) == 1) write_a($urandom_range(0, 3), a0, d);
      else read_a($urandom_range(0, 3), a0);
    end

    // Reset while waiting on a 5-cycle memory.
    lat_a = 5;
    rv_a[1] = 1'b1; ra_a[15:8] = 8'h77;
    repeat (2) @(negedge clk);
    check("mid_issued", 32'(mrv_a), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_outs", {22'd0, rr_a, wr_a, mrv_a, mwv_a}, 0);
    check("mid_rst_rdata", 32'(|rd_a), 0);
    reset = 1'b0;
    rv_a[1] = 1'b0;
    stray_a = 1'b1;
    @(negedge clk);
    stray_a = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_ignored", {27'd0, rr_a, mrv_a}, 0);
    check("stray_rdata", 32'(|rd_a), 0);
    read_a(1, 8'h77);

    // Instance B: two channels take two consumers in the same cycle.
    a0 = 8'($urandom); a1 = 8'($urandom);
    rv_b = 4'b0011; ra_b[7:0] = a0; ra_b[15:8] = a1;
    @(negedge clk);
    check("two_ch_valid", 32'(mrv_b), 3);
    check("two_ch_addr0", 32'(mra_b[7:0]), 32'(a0));
    check("two_ch_addr1", 32'(mra_b[15:8]), 32'(a1));
    @(negedge clk);
    check("two_ch_ready", 32'(rr_b), 3);
    check("two_ch_data0", 32'(rd_b[15:0]), 32'(ref_mem[a0]));
    check("two_ch_data1", 32'(rd_b[31:16]), 32'(ref_mem[a1]));
    rv_b = 4'b0000;
    @(negedge clk);
    check("two_ch_drop", 32'(rr_b), 0);

    // A single request must occupy only one channel.
    rv_b[2] = 1'b1; ra_b[23:16] = 8'h12;
    @(negedge clk);
    check("no_double_claim", 32'(mrv_b), 1);
    @(negedge clk);
    check("single_b_ready", 32'(rr_b), 4);
    check("single_b_data", 32'(rd_b[47:32]), 32'(ref_mem[8'h12]));
    rv_b[2] = 1'b0;
    @(negedge clk);

    // Read-only instance ignores writes; reads still go through.
    wv_b[1] = 1'b1; wa_b[15:8] = 8'h99; wd_b[31:16] = 16'hCAFE;
    rv_b[3] = 1'b1; ra_b[31:24] = 8'h66;
    wr_seen = 1'b0; t_ro = -1;
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      if ((|mwv_b) || (|wr_b) || (|mwa_b) || (|mwd_b)) wr_seen = 1'b1;
      if (t_ro < 0 && rr_b[3]) t_ro = t;
    end
    check("ro_no_write", 32'(wr_seen), 0);
    check("ro_read_time", t_ro, 2);
    check("ro_read_data", 32'(rd_b[63:48]), 32'(ref_mem[8'h66]));
    rv_b[3] = 1'b0; wv_b[1] = 1'b0;
    @(negedge clk);
    check("ro_drop", 32'(rr_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
